// File: rtl/set_pkg.sv
// set_pkg: shared FSM encoding, field indices and game-build limit vectors for param_set_ctrl.
package set_pkg;
  typedef enum logic {ST_EDIT, ST_DONE} state_t;
  localparam int F_PLAYERS = 0;
  localparam int F_TIME = 1;
  localparam int F_ADD_PTS = 2;
  localparam int F_SUB_PTS = 3;
  localparam int GAME_FIELDS = 4;
  localparam int GAME_VAL_W = 7;
  localparam logic [GAME_FIELDS*GAME_VAL_W-1:0] GAME_MIN = {7'd0, 7'd0, 7'd0, 7'd1};
  localparam logic [GAME_FIELDS*GAME_VAL_W-1:0] GAME_MAX = {7'd15, 7'd15, 7'd99, 7'd7};
  localparam logic [GAME_FIELDS*GAME_VAL_W-1:0] GAME_DEF = {7'd1, 7'd1, 7'd30, 7'd2};
endpackage

// File: rtl/set_btn_event.sv
// set_btn_event: rising-edge event from a debounced button level, with optional hold auto-repeat.
module set_btn_event #(
  parameter bit REPEAT_EN = 1'b0,
  parameter int HOLD_CYCLES = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  input  logic clear,
  output logic pulse
);
  logic prev_q;
  logic press;
  // Loading the live level during reset keeps a button held across reset from firing.
  always_ff @(posedge clk)
    if (rst) prev_q <= level;
    else prev_q <= level;
  assign press = level & ~prev_q & ~clear;
  if (REPEAT_EN) begin : g_rep
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic fire;
    assign fire = level & prev_q & ~clear & (cnt_q == CNT_W'(HOLD_CYCLES));
    // After a repeat fires the counter rewinds so it reaches HOLD again REPEAT cycles later.
    always_comb cnt_d = (clear || !level) ? '0
                      : fire ? CNT_W'(HOLD_CYCLES - REPEAT_CYCLES + 1)
                      : cnt_q + 1'b1;
    always_ff @(posedge clk)
      if (rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
    assign pulse = press | fire;
  end else begin : g_norep
    assign pulse = press;
  end
endmodule

// File: rtl/param_set_ctrl.sv
// param_set_ctrl: settings-entry FSM stepping through NUM_FIELDS limited fields with add/sub/confirm.
// Define SET_AUTOREPEAT_EN to build hold auto-repeat on the add/sub buttons.
module param_set_ctrl
  import set_pkg::*;
#(
  parameter int NUM_FIELDS = GAME_FIELDS,
  parameter int VAL_W = GAME_VAL_W,
  parameter logic [NUM_FIELDS*VAL_W-1:0] FIELD_MIN = GAME_MIN,
  parameter logic [NUM_FIELDS*VAL_W-1:0] FIELD_MAX = GAME_MAX,
  parameter logic [NUM_FIELDS*VAL_W-1:0] FIELD_DEF = GAME_DEF,
  parameter bit WRAP = 1'b0,
  parameter int HOLD_CYCLES = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  localparam int IDX_W = $clog2(NUM_FIELDS)
) (
  input  logic clk,
  input  logic rst,
  input  logic add,
  input  logic sub,
  input  logic confirm,
  output logic [IDX_W-1:0] field_idx,
  output logic [VAL_W-1:0] cur_value,
  output logic [NUM_FIELDS*VAL_W-1:0] values,
  output logic changed,
  output logic finish
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_FIELDS - 1);
`ifdef SET_AUTOREPEAT_EN
  localparam bit AR_EN = 1'b1;
`else
  localparam bit AR_EN = 1'b0;
`endif
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [VAL_W-1:0] val_q [NUM_FIELDS];
  logic [VAL_W-1:0] val_d [NUM_FIELDS];
  logic changed_q, changed_d;
  logic add_ev, sub_ev, conf_ev, edit;
  logic [VAL_W-1:0] cur, lo, hi, nxt;
  set_btn_event #(.REPEAT_EN(AR_EN), .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES))
    u_add (.clk(clk), .rst(rst), .level(add), .clear(conf_ev), .pulse(add_ev));
  set_btn_event #(.REPEAT_EN(AR_EN), .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES))
    u_sub (.clk(clk), .rst(rst), .level(sub), .clear(conf_ev), .pulse(sub_ev));
  set_btn_event #(.REPEAT_EN(1'b0), .HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES))
    u_conf (.clk(clk), .rst(rst), .level(confirm), .clear(1'b0), .pulse(conf_ev));
  assign edit = state_q == ST_EDIT;
  assign cur = val_q[idx_q];
  assign lo = FIELD_MIN[idx_q*VAL_W +: VAL_W];
  assign hi = FIELD_MAX[idx_q*VAL_W +: VAL_W];
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    val_d = val_q;
    changed_d = 1'b0;
    nxt = cur;
    if (add_ev && !sub_ev) nxt = cur < hi ? cur + 1'b1 : (WRAP ? lo : cur);
    else if (sub_ev && !add_ev) nxt = cur > lo ? cur - 1'b1 : (WRAP ? hi : cur);
    if (edit && conf_ev) begin
      state_d = idx_q == LAST ? ST_DONE : ST_EDIT;
      idx_d = idx_q == LAST ? idx_q : idx_q + 1'b1;
    end else if (edit) begin
      val_d[idx_q] = nxt;
      changed_d = nxt != cur;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= ST_EDIT;
      idx_q <= '0;
      changed_q <= 1'b0;
      for (int i = 0; i < NUM_FIELDS; i++) val_q[i] <= FIELD_DEF[i*VAL_W +: VAL_W];
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      changed_q <= changed_d;
      val_q <= val_d;
    end
  for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_out
    assign values[i*VAL_W +: VAL_W] = val_q[i];
  end
  assign field_idx = idx_q;
  assign cur_value = cur;
  assign changed = changed_q;
  assign finish = state_q == ST_DONE;
endmodule

// File: tb/tb_param_set_ctrl.sv
// tb_param_set_ctrl: directed vector table plus hand sequences for param_set_ctrl (saturate and wrap builds).
module tb_param_set_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1, add = 1'b0, sub = 1'b0, confirm = 1'b0;
  logic w_rst = 1'b1, w_add = 1'b0, w_sub = 1'b0, w_confirm = 1'b0;
  logic [1:0] field_idx, w_idx;
  logic [6:0] cur_value, w_cur;
  logic [27:0] values, w_values;
  logic changed, finish, w_changed, w_finish;
  int checks = 0;
  int fails = 0;
  always #5 clk = ~clk;
  param_set_ctrl #(.HOLD_CYCLES(4), .REPEAT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .add(add), .sub(sub), .confirm(confirm),
    .field_idx(field_idx), .cur_value(cur_value), .values(values),
    .changed(changed), .finish(finish));
  param_set_ctrl #(.WRAP(1'b1)) dut_w (
    .clk(clk), .rst(w_rst), .add(w_add), .sub(w_sub), .confirm(w_confirm),
    .field_idx(w_idx), .cur_value(w_cur), .values(w_values),
    .changed(w_changed), .finish(w_finish));
  typedef struct {
    logic a, s, c, r;
    int idx, cur;
    logic fin, chg;
  } vec_t;
  vec_t tv[$];
  function automatic void v(logic a, logic s, logic c, logic r, int idx, int cur, logic fin, logic chg);
    vec_t t;
    t.a = a; t.s = s; t.c = c; t.r = r; t.idx = idx; t.cur = cur; t.fin = fin; t.chg = chg;
    tv.push_back(t);
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic step(input logic a, input logic s, input logic c, input logic r);
    add = a; sub = s; confirm = c; rst = r;
    @(negedge clk);
  endtask
  task automatic wstep(input logic a, input logic s, input logic c, input logic r);
    w_add = a; w_sub = s; w_confirm = c; w_rst = r;
    @(negedge clk);
  endtask
  initial begin
    int exp;
    v(0,0,0,1, 0,2,0,0);
    v(0,0,0,0, 0,2,0,0);
    for (int p = 0; p < 10; p++) begin
      exp = (3 + p > 7) ? 7 : 3 + p;
      v(1,0,0,0, 0,exp,0,p < 5);
      v(0,0,0,0, 0,exp,0,0);
    end
    v(1,1,0,0, 0,7,0,0); v(0,0,0,0, 0,7,0,0);
    v(0,1,0,0, 0,6,0,1); v(0,0,0,0, 0,6,0,0);
    v(0,0,1,0, 1,30,0,0); v(0,0,0,0, 1,30,0,0);
    v(0,0,1,0, 2,1,0,0); v(0,0,0,0, 2,1,0,0);
    v(0,0,1,0, 3,1,0,0); v(0,0,0,0, 3,1,0,0);
    v(0,0,1,0, 3,1,1,0); v(0,0,0,0, 3,1,1,0);
    v(1,0,0,0, 3,1,1,0); v(0,0,0,0, 3,1,1,0);
    v(0,0,1,0, 3,1,1,0); v(0,0,0,0, 3,1,1,0);
    v(0,1,0,0, 3,1,1,0); v(0,0,0,0, 3,1,1,0);
    @(negedge clk);
    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].a, tv[i].s, tv[i].c, tv[i].r);
      chk($sformatf("v%0d_idx", i), 32'(field_idx), tv[i].idx);
      chk($sformatf("v%0d_cur", i), 32'(cur_value), tv[i].cur);
      chk($sformatf("v%0d_finish", i), 32'(finish), 32'(tv[i].fin));
      chk($sformatf("v%0d_changed", i), 32'(changed), 32'(tv[i].chg));
    end
    // Reset defaults, confirm beats add, reset mid-edit.
    step(0,0,0,1);
    chk("rst_values", 32'(values), 32'({7'd1, 7'd1, 7'd30, 7'd2}));
    step(0,0,1,0); step(0,0,0,0);
    step(1,0,1,0);
    chk("conf_add_idx", 32'(field_idx), 2);
    chk("conf_add_f1", 32'(values[13:7]), 30);
    chk("conf_add_chg", 32'(changed), 0);
    step(0,0,0,0);
    step(1,0,0,0);
    chk("f2_add", 32'(cur_value), 2);
    chk("f2_add_chg", 32'(changed), 1);
    step(0,0,0,0);
    step(0,0,0,1);
    chk("midrst_values", 32'(values), 32'({7'd1, 7'd1, 7'd30, 7'd2}));
    chk("midrst_idx", 32'(field_idx), 0);
    chk("midrst_finish", 32'(finish), 0);
    // Button held through reset release must not fire until re-pressed.
    step(1,0,0,1);
    step(1,0,0,0);
    chk("held_rst_cur", 32'(cur_value), 2);
    chk("held_rst_chg", 32'(changed), 0);
    step(0,0,0,0);
    step(1,0,0,0);
    chk("repress_cur", 32'(cur_value), 3);
    // Sub saturates at field0 minimum.
    step(0,0,0,0);
    step(0,1,0,0); step(0,0,0,0);
    step(0,1,0,0); step(0,0,0,0);
    step(0,1,0,0);
    chk("sub_sat_cur", 32'(cur_value), 1);
    chk("sub_sat_chg", 32'(changed), 0);
    step(0,0,0,0);
    // Long hold on field1.
    step(0,0,0,1);
    step(0,0,1,0); step(0,0,0,0);
    add = 1'b1;
    repeat (10) @(negedge clk);
    add = 1'b0;
    @(negedge clk);
`ifdef SET_AUTOREPEAT_EN
    chk("hold_f1", 32'(values[13:7]), 34);
`else
    chk("hold_f1", 32'(values[13:7]), 31);
`endif
    // Wrap build.
    wstep(0,0,0,1);
    wstep(0,0,0,0);
    wstep(0,1,0,0); wstep(0,0,0,0);
    chk("wrap_f0_1", 32'(w_cur), 1);
    wstep(0,1,0,0);
    chk("wrap_f0_max", 32'(w_cur), 7);
    chk("wrap_f0_chg", 32'(w_changed), 1);
    wstep(0,0,0,0);
    wstep(0,0,1,0); wstep(0,0,0,0);
    chk("wrap_idx", 32'(w_idx), 1);
    for (int i = 0; i < 69; i++) begin
      wstep(1,0,0,0); wstep(0,0,0,0);
    end
    chk("wrap_f1_99", 32'(w_cur), 99);
    wstep(1,0,0,0);
    chk("wrap_f1_min", 32'(w_cur), 0);
    chk("wrap_f1_chg", 32'(w_changed), 1);
    wstep(0,0,0,0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
